// File: rtl/uart_echo_buffer.sv
// Echo buffer between UART RX and TX: FIFO-decoupled loopback with pause/drain,
// overflow/drop accounting and a shifting hex history for 7-segment digits.
module uart_echo_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int NUM_DIGITS     = 2,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_RX_DV,
  input  logic [DATA_WIDTH-1:0]         i_RX_Byte,
  input  logic                          i_TX_Active,
  input  logic                          i_Pause,
  input  logic                          i_Clear_Ovf,
  output logic                          o_TX_DV,
  output logic [DATA_WIDTH-1:0]         o_TX_Byte,
  output logic [4*NUM_DIGITS-1:0]       o_Display,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fill_Level,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic                          o_Overflow,
  output logic [DROP_CNT_WIDTH-1:0]     o_Drop_Count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END} state_t;

  logic [DATA_WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  state_t                       state;
  logic                         pop, push, drop;
  logic [LW-1:0]                level_nxt;
  logic [DISP_W+DATA_WIDTH-1:0] disp_shift;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    pop        = (state == IDLE) && !o_Empty && !i_Pause && !i_TX_Active;
    push       = i_RX_DV && (!o_Full || pop);
    drop       = i_RX_DV && !push;
    level_nxt  = o_Fill_Level + LW'(push) - LW'(pop);
    disp_shift = {o_Display, i_RX_Byte};
  end

  // Storage carries no reset; only pointers define valid contents.
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_Fill_Level <= '0;
      o_Full       <= 1'b0;
      o_Empty      <= 1'b1;
      o_TX_DV      <= 1'b0;
      o_TX_Byte    <= '0;
      o_Display    <= '0;
      o_Overflow   <= 1'b0;
      o_Drop_Count <= '0;
      state        <= IDLE;
    end else begin
      o_TX_DV <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_Fill_Level <= level_nxt;
      o_Full       <= (level_nxt == LW'(FIFO_DEPTH));
      o_Empty      <= (level_nxt == '0);

      if (i_RX_DV) o_Display <= disp_shift[DISP_W-1:0];

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        o_Overflow <= 1'b1;
        if (i_Clear_Ovf)              o_Drop_Count <= DROP_CNT_WIDTH'(1);
        else if (o_Drop_Count != CNT_MAX) o_Drop_Count <= o_Drop_Count + DROP_CNT_WIDTH'(1);
      end else if (i_Clear_Ovf) begin
        o_Overflow   <= 1'b0;
        o_Drop_Count <= '0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            o_TX_Byte <= mem[rd_ptr];
            o_TX_DV   <= 1'b1;
            state     <= WAIT_START;
          end
        end
        WAIT_START: if (i_TX_Active)  state <= WAIT_END;
        WAIT_END:   if (!i_TX_Active) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: table-driven latency/pause vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_uart_echo_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0, tx_active = 1'b0, pause = 1'b0, clr = 1'b0;
  logic [7:0] rx = 8'h00;

  logic        tx_dv, full, empty, ovf;
  logic [7:0]  tx_byte, drops;
  logic [15:0] disp;
  logic [4:0]  level;

  logic        tx_dv2, full2, empty2, ovf2;
  logic [7:0]  tx_byte2;
  logic [1:0]  drops2;
  logic [15:0] disp2;
  logic [4:0]  level2;

  uart_echo_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .NUM_DIGITS(4), .DROP_CNT_WIDTH(8)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx), .i_TX_Active(tx_active),
    .i_Pause(pause), .i_Clear_Ovf(clr), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_Display(disp),
    .o_Fill_Level(level), .o_Full(full), .o_Empty(empty), .o_Overflow(ovf), .o_Drop_Count(drops));

  uart_echo_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .NUM_DIGITS(4), .DROP_CNT_WIDTH(2)) dut_w2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx), .i_TX_Active(tx_active),
    .i_Pause(pause), .i_Clear_Ovf(clr), .o_TX_DV(tx_dv2), .o_TX_Byte(tx_byte2), .o_Display(disp2),
    .o_Fill_Level(level2), .o_Full(full2), .o_Empty(empty2), .o_Overflow(ovf2), .o_Drop_Count(drops2));

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words in flight as a queue, one outstanding frame at a time.
  logic [7:0]  q[$];
  logic [7:0]  seen[$];
  bit          m_busy, m_saw, m_dv, m_ovf;
  logic [7:0]  m_byte;
  logic [15:0] m_disp;
  int          m_drops;

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_saw = 0; m_dv = 0; m_ovf = 0;
    m_byte = 8'h00; m_disp = 16'h0000; m_drops = 0;
  endtask

  task automatic model_edge();
    bit do_pop, dropped;
    do_pop  = !m_busy && (q.size() > 0) && !pause && !tx_active;
    dropped = rx_dv && (q.size() == 16) && !do_pop;
    m_dv = 0;
    if (m_busy) begin
      if (!m_saw) begin
        if (tx_active) m_saw = 1;
      end else if (!tx_active) m_busy = 0;
    end
    if (do_pop) begin
      m_byte = q.pop_front();
      m_dv = 1; m_busy = 1; m_saw = 0;
    end
    if (rx_dv) begin
      m_disp = {m_disp[7:0], rx};
      if (!dropped) q.push_back(rx);
    end
    if (dropped) begin
      m_ovf = 1;
      m_drops = clr ? 1 : m_drops + 1;
    end else if (clr) begin
      m_ovf = 0; m_drops = 0;
    end
  endtask

  task automatic check_outputs();
    chk("tx_dv",      64'(tx_dv),   64'(m_dv));
    chk("tx_byte",    64'(tx_byte), 64'(m_byte));
    chk("display",    64'(disp),    64'(m_disp));
    chk("level",      64'(level),   64'(q.size()));
    chk("full",       64'(full),    64'(q.size() == 16));
    chk("empty",      64'(empty),   64'(q.size() == 0));
    chk("overflow",   64'(ovf),     64'(m_ovf));
    chk("drop_count", 64'(drops),   64'((m_drops > 255) ? 255 : m_drops));
    chk("w2_drop_count", 64'(drops2), 64'((m_drops > 3) ? 3 : m_drops));
    chk("w2_overflow",   64'(ovf2),   64'(m_ovf));
    chk("w2_tx_dv",      64'(tx_dv2), 64'(m_dv));
    chk("w2_level",      64'(level2), 64'(q.size()));
    if (tx_dv === 1'b1) seen.push_back(tx_byte);
  endtask

  // UART TX stand-in: after each strobe, go busy after a short delay for a few cycles.
  bit auto_tx = 0;
  int start_in = 0, act_len = 0;

  task automatic responder();
    if (auto_tx) begin
      if (start_in > 0) begin
        start_in--;
        if (start_in == 0) begin
          tx_active = 1'b1;
          act_len = int'($urandom_range(1, 4));
        end
      end else if (tx_active) begin
        act_len--;
        if (act_len <= 0) tx_active = 1'b0;
      end
      if (tx_dv === 1'b1) start_in = int'($urandom_range(1, 3));
    end
  endtask

  task automatic step(input bit dv, input logic [7:0] b, input bit c);
    rx_dv = dv; rx = b; clr = c;
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    rx_dv = 1'b0; clr = 1'b0;
    check_outputs();
    responder();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic async_reset(input bit do_chk);
    #3 rst_n = 1'b0;
    #1;
    if (do_chk) begin
      chk("rst_level",   64'(level),   64'd0);
      chk("rst_empty",   64'(empty),   64'd1);
      chk("rst_full",    64'(full),    64'd0);
      chk("rst_tx_dv",   64'(tx_dv),   64'd0);
      chk("rst_tx_byte", 64'(tx_byte), 64'd0);
      chk("rst_display", 64'(disp),    64'd0);
      chk("rst_ovf",     64'(ovf),     64'd0);
      chk("rst_drops",   64'(drops),   64'd0);
    end
    model_reset();
    auto_tx = 0; start_in = 0; act_len = 0; tx_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          dv;
    logic [7:0]  b;
    bit          act;
    bit          pse;
    bit          e_dv;
    logic [7:0]  e_byte;
    int          e_lvl;
    logic [15:0] e_disp;
  } vec_t;

  vec_t tbl[11];
  int   guard, n_dv;

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1, 16'h00A5};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 16'h00A5};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 16'h00A5};
    tbl[3]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1, 16'hA53C};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 16'hA53C};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 16'hA53C};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 16'hA53C};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 16'hA53C};
    tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h3C, 1, 16'h3C77};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1, 16'h3C77};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 0, 16'h3C77};

    // Power-on reset values
    repeat (2) @(negedge clk);
    chk("por_level",   64'(level),   64'd0);
    chk("por_empty",   64'(empty),   64'd1);
    chk("por_full",    64'(full),    64'd0);
    chk("por_tx_dv",   64'(tx_dv),   64'd0);
    chk("por_tx_byte", 64'(tx_byte), 64'd0);
    chk("por_display", 64'(disp),    64'd0);
    chk("por_ovf",     64'(ovf),     64'd0);
    chk("por_drops",   64'(drops),   64'd0);
    model_reset();
    rst_n = 1'b1;

    // Latency, echo and pause vectors
    for (int i = 0; i < 11; i++) begin
      tx_active = tbl[i].act;
      pause     = tbl[i].pse;
      step(tbl[i].dv, tbl[i].b, 1'b0);
      chk($sformatf("vec%0d_tx_dv", i),   64'(tx_dv),   64'(tbl[i].e_dv));
      chk($sformatf("vec%0d_tx_byte", i), 64'(tx_byte), 64'(tbl[i].e_byte));
      chk($sformatf("vec%0d_level", i),   64'(level),   64'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_empty", i),   64'(empty),   64'(tbl[i].e_lvl == 0));
      chk($sformatf("vec%0d_display", i), 64'(disp),    64'(tbl[i].e_disp));
    end
    pause = 1'b0;

    // Burst while TX is busy, then drain in order
    tx_active = 1'b1;
    idle(1);
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    chk("burst_level", 64'(level), 64'd5);
    seen.delete();
    tx_active = 1'b0;
    auto_tx = 1;
    guard = 0;
    while (seen.size() < 5 && guard < 200) begin idle(1); guard++; end
    chk("burst_count", 64'(seen.size()), 64'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk($sformatf("burst_word%0d", i), 64'(seen[i]), 64'(i + 1));
    idle(20);

    // Overflow while paused
    pause = 1'b1;
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    chk("ovf_full",    64'(full),  64'd1);
    chk("ovf_level",   64'(level), 64'd16);
    chk("ovf_flag",    64'(ovf),   64'd1);
    chk("ovf_drops",   64'(drops), 64'd2);
    chk("ovf_display", 64'(disp),  64'h9091);

    // Full FIFO: push in the same cycle as the pop is accepted
    seen.delete();
    pause = 1'b0;
    step(1'b1, 8'hC0, 1'b0);
    chk("pp_tx_dv",   64'(tx_dv),   64'd1);
    chk("pp_tx_byte", 64'(tx_byte), 64'h80);
    chk("pp_level",   64'(level),   64'd16);
    chk("pp_drops",   64'(drops),   64'd2);
    guard = 0;
    while (seen.size() < 17 && guard < 600) begin idle(1); guard++; end
    chk("pp_count", 64'(seen.size()), 64'd17);
    for (int i = 0; i < 16 && i < seen.size(); i++)
      chk($sformatf("pp_word%0d", i), 64'(seen[i]), 64'(8'h80 + i));
    if (seen.size() >= 17) chk("pp_word16", 64'(seen[16]), 64'hC0);
    idle(20);

    // Clear coinciding with a drop, lone clear, saturation
    pause = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("clrdrop_ovf",   64'(ovf),    64'd1);
    chk("clrdrop_drops", 64'(drops),  64'd1);
    chk("clrdrop_w2",    64'(drops2), 64'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("clr_ovf",   64'(ovf),   64'd0);
    chk("clr_drops", 64'(drops), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    chk("sat_drops8", 64'(drops),  64'd5);
    chk("sat_drops2", 64'(drops2), 64'd3);
    chk("sat_level",  64'(level),  64'd16);

    // Asynchronous reset mid-burst with seven words queued
    async_reset(1'b0);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_rst_level", 64'(level), 64'd7);
    async_reset(1'b1);
    pause = 1'b0;
    n_dv = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (tx_dv !== 1'b0) n_dv++;
    end
    chk("post_rst_no_tx", 64'(n_dv), 64'd0);

    // Randomized traffic against the model
    auto_tx = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 31) == 0) pause = ~pause;
      step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
